xpb_table_builder: RTL and testbench

Sequential generator for the 32-entry reduction-multiple tables used by the modular-square datapath: given a base constant B and modulus M, writes entry j = (j·B) mod M for j = 0..31 through a single write port. It is the writer for the lookup tables that the xpb stages read with a 5-bit digit, so those tables can be reloaded at run time for a new modulus.

---
 rtl/xpb_table_builder_if.sv | 25 ++
 rtl/xpb_table_builder.sv | 92 +++++++++
 tb/tb_xpb_table_builder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/xpb_table_builder_if.sv
// xpb_table_builder_if: build request and table write port of the xpb table builder
interface xpb_table_builder_if #(
    parameter int W          = 1024,
    parameter int DIGIT_BITS = 5
);
    logic                  start;
    logic [W-1:0]          base_in;
    logic [W-1:0]          modulus_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  wr_en;
    logic [DIGIT_BITS-1:0] wr_addr;
    logic [W-1:0]          wr_data;

    modport master (
        output start, base_in, modulus_in,
        input  busy, done, err, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, base_in, modulus_in,
        output busy, done, err, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/xpb_table_builder.sv
// xpb_table_builder: writes entry j = (j*B) mod M for j = 0..2^DIGIT_BITS-1, one entry every two cycles
module xpb_table_builder #(
    parameter int W          = 1024,
    parameter int DIGIT_BITS = 5
) (
    input logic               clk,
    input logic               rst_n,
    xpb_table_builder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INIT, ADD, RED, FIN} state_t;

    state_t                state;
    logic [W-1:0]          b_r;
    logic [W-1:0]          m_r;
    logic [W-1:0]          acc;
    logic [W:0]            sum;
    logic [DIGIT_BITS-1:0] j;
    logic [W+1:0]          diff;
    logic [W-1:0]          result;

    // sum < 2M because acc < M and B < M, so one conditional subtract reduces it
    assign diff   = {1'b0, sum} - {2'b00, m_r};
    assign result = diff[W+1] ? sum[W-1:0] : diff[W-1:0];

    // Outputs are registered on entry to the cycle they describe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            b_r         <= '0;
            m_r         <= '0;
            acc         <= '0;
            sum         <= '0;
            j           <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    b_r <= bus.base_in;
                    m_r <= bus.modulus_in;
                    if (bus.base_in >= bus.modulus_in) begin
                        state    <= FIN;
                        bus.done <= 1'b1;
                        bus.err  <= 1'b1;
                    end else begin
                        state       <= INIT;
                        bus.busy    <= 1'b1;
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= '0;
                        bus.wr_data <= '0;
                        acc         <= '0;
                        j           <= DIGIT_BITS'(1);
                    end
                end
                INIT: begin
                    state     <= ADD;
                    bus.wr_en <= 1'b0;
                    sum       <= {1'b0, b_r};
                end
                ADD: begin
                    state       <= RED;
                    acc         <= result;
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= j;
                    bus.wr_data <= result;
                end
                RED: begin
                    bus.wr_en <= 1'b0;
                    if (&j) begin
                        state    <= FIN;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        state <= ADD;
                        j     <= j + 1'b1;
                        sum   <= {1'b0, acc} + {1'b0, b_r};
                    end
                end
                FIN: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.err  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xpb_table_builder.sv
// tb_xpb_table_builder: directed W=16 vectors plus random W=1024 builds against a modulo model
module tb_xpb_table_builder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xpb_table_builder_if #(.W(16),   .DIGIT_BITS(5)) s16 ();
    xpb_table_builder_if #(.W(1024), .DIGIT_BITS(5)) s1k ();

    xpb_table_builder #(.W(16),   .DIGIT_BITS(5)) dut16 (.clk(clk), .rst_n(rst_n), .bus(s16));
    xpb_table_builder #(.W(1024), .DIGIT_BITS(5)) dut1k (.clk(clk), .rst_n(rst_n), .bus(s1k));

    typedef struct {
        logic [15:0] b;
        logic [15:0] m;
        logic        e;
    } vec_t;

    typedef struct {
        int          v;
        int          addr;
        logic [15:0] data;
    } spot_t;

    int errors = 0;
    int checks = 0;

    logic [15:0]   tab16 [32];
    logic [1023:0] tab1k [32];
    int            nwr, dcyc, order_bad, busy_bad;
    logic          derr;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model16(input logic [15:0] b, input logic [15:0] m, input int j);
        logic [31:0] p;
        p = 32'(b) * 32'(j);
        return 16'(p % 32'(m));
    endfunction

    // Drive one W=16 build; optionally re-pulse start with base b2 at cycle start+repulse
    task automatic run16(input logic [15:0] b, input logic [15:0] m, input int repulse, input logic [15:0] b2);
        logic exp_busy;
        nwr = 0; dcyc = -1; derr = 1'b0; order_bad = 0; busy_bad = 0;
        foreach (tab16[i]) tab16[i] = 'x;
        @(negedge clk);
        s16.start = 1'b1; s16.base_in = b; s16.modulus_in = m;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            s16.start      = (k == repulse);
            s16.base_in    = (k == repulse) ? b2 : 16'hA5A5;
            s16.modulus_in = 16'h5A5A;
            exp_busy = (b < m) && (k <= 63);
            if (s16.busy !== exp_busy) busy_bad++;
            if (s16.wr_en) begin
                if (int'(s16.wr_addr) != nwr || k != 1 + 2 * nwr) order_bad++;
                tab16[s16.wr_addr] = s16.wr_data;
                nwr++;
            end
            if (s16.done) begin
                dcyc = k;
                derr = s16.err;
                break;
            end
        end
        s16.start = 1'b0;
    endtask

    task automatic run1k();
        logic [1023:0] b, m, e;
        logic [1028:0] p;
        int bad;
        for (int w = 0; w < 32; w++) begin
            m[32*w +: 32] = $urandom;
            b[32*w +: 32] = $urandom;
        end
        m[1023] = 1'b1;
        m[0]    = 1'b1;
        b       = b % m;
        nwr = 0; dcyc = -1; bad = 0;
        foreach (tab1k[i]) tab1k[i] = 'x;
        @(negedge clk);
        s1k.start = 1'b1; s1k.base_in = b; s1k.modulus_in = m;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            s1k.start = 1'b0;
            if (s1k.wr_en) begin
                tab1k[s1k.wr_addr] = s1k.wr_data;
                nwr++;
            end
            if (s1k.done) begin
                dcyc = k;
                break;
            end
        end
        for (int j = 0; j < 32; j++) begin
            p = 1029'(b) * 1029'(j);
            e = 1024'(p % {5'b0, m});
            if (tab1k[j] !== e) bad++;
        end
        chk("w1k_latency", dcyc, 64);
        chk("w1k_nwr", nwr, 32);
        chk("w1k_bad_entries", bad, 0);
    endtask

    initial begin
        vec_t  vecs  [6];
        spot_t spots [8];
        int    stray;
        vecs = '{
            '{16'h8000, 16'hFFF1, 1'b0},
            '{16'hFFF0, 16'hFFF1, 1'b0},
            '{16'h0000, 16'hFFF1, 1'b0},
            '{16'hFFF1, 16'hFFF1, 1'b1},
            '{16'h0005, 16'h0007, 1'b0},
            '{16'hFFFF, 16'h0003, 1'b1}
        };
        spots = '{
            '{0, 0, 16'h0000}, '{0, 1, 16'h8000}, '{0, 2, 16'h000F}, '{0, 3, 16'h800F},
            '{0, 4, 16'h001E}, '{1, 1, 16'hFFF0}, '{1, 2, 16'hFFEF}, '{1, 31, 16'hFFD2}
        };
        s16.start = 1'b0; s16.base_in = '0; s16.modulus_in = '0;
        s1k.start = 1'b0; s1k.base_in = '0; s1k.modulus_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", s16.busy, 0);
        chk("rst_done", s16.done, 0);
        chk("rst_err", s16.err, 0);
        chk("rst_wr_en", s16.wr_en, 0);
        chk("rst_wr_addr", s16.wr_addr, 0);
        chk("rst_wr_data", s16.wr_data, 0);
        chk("rst_1k_outputs", {s1k.busy, s1k.done, s1k.err, s1k.wr_en, s1k.wr_addr, s1k.wr_data}, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run16(vecs[v].b, vecs[v].m, 0, 16'h0);
            chk($sformatf("v%0d_done_cycle", v), dcyc, vecs[v].e ? 1 : 64);
            chk($sformatf("v%0d_err", v), derr, vecs[v].e);
            chk($sformatf("v%0d_nwr", v), nwr, vecs[v].e ? 0 : 32);
            chk($sformatf("v%0d_order", v), order_bad, 0);
            chk($sformatf("v%0d_busy", v), busy_bad, 0);
            if (!vecs[v].e)
                for (int j = 0; j < 32; j++)
                    chk($sformatf("v%0d_entry%0d", v, j), tab16[j], model16(vecs[v].b, vecs[v].m, j));
            foreach (spots[s])
                if (spots[s].v == v)
                    chk($sformatf("v%0d_spot%0d", v, spots[s].addr), tab16[spots[s].addr], spots[s].data);
        end

        // start re-pulsed mid-build must be ignored
        run16(16'h8000, 16'hFFF1, 10, 16'h1234);
        chk("repulse_done_cycle", dcyc, 64);
        chk("repulse_nwr", nwr, 32);
        for (int j = 0; j < 32; j++)
            chk($sformatf("repulse_entry%0d", j), tab16[j], model16(16'h8000, 16'hFFF1, j));
        repeat (3) @(negedge clk);
        chk("repulse_no_second_build", s16.busy, 0);

        // reset asserted (together with start) during the write of addr 10
        @(negedge clk);
        s16.start = 1'b1; s16.base_in = 16'h8000; s16.modulus_in = 16'hFFF1;
        @(negedge clk);
        s16.start = 1'b0;
        for (int k = 0; k < 40 && !(s16.wr_en && s16.wr_addr == 5'd10); k++) @(negedge clk);
        chk("midrst_reached_addr10", {s16.wr_en, s16.wr_addr}, {1'b1, 5'd10});
        rst_n = 1'b0;
        s16.start = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {s16.busy, s16.done, s16.err, s16.wr_en, s16.wr_addr, s16.wr_data}, 0);
        s16.start = 1'b0;
        rst_n = 1'b1;
        stray = 0;
        repeat (70) begin
            @(negedge clk);
            if (s16.wr_en || s16.busy || s16.done) stray++;
        end
        chk("midrst_no_activity", stray, 0);
        run16(16'h0005, 16'h0007, 0, 16'h0);
        chk("midrst_recover_done", dcyc, 64);
        chk("midrst_recover_entry31", tab16[31], model16(16'h0005, 16'h0007, 31));

        for (int r = 0; r < 100; r++) run1k();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
